// File: rtl/scan_sram_bridge.sv
// Scan-side bridge onto the ping-pong FFT SRAM banks: arbitrates against fft_busy and sequences macro read latency.
// Optional WAIT_OWN timeout under `SCAN_SRAM_BRIDGE_TIMEOUT_EN; sram_ready is a single pulse and the request must drop before the next access.
module scan_sram_bridge #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sram_ren,
  input  logic              sram_wen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ready,
  input  logic              select_sram_reg,
  input  logic              fft_busy,
  output logic              scan_owns_mem,
  output logic              mem0_cen,
  output logic              mem1_cen,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem0_rdata,
  input  logic [DATA_W-1:0] mem1_rdata,
  output logic              timeout_flag
);

  typedef enum logic [2:0] {IDLE, WAIT_OWN, ACCESS, RDWAIT, RESP, HOLD} state_t;

  localparam int LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

  state_t            state, state_nxt;
  logic              req;
  logic              we_q, bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, bank_rdata;
  logic [LAT_W-1:0]  lat_cnt;
  logic              rd_done;
  logic              to_fire;
  logic              timed_out;

  assign req        = sram_ren | sram_wen;
  assign bank_rdata = bank_q ? mem1_rdata : mem0_rdata;
  assign rd_done    = (lat_cnt == LAT_W'(READ_LATENCY - 2));

  // Macro data is only valid during RESP, so pass it straight through then and hold the copy afterwards.
  assign sram_rdata = (state == RESP && !we_q && !timed_out) ? bank_rdata : rdata_q;

`ifdef SCAN_SRAM_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag_q;

  assign to_fire      = (state == WAIT_OWN) && fft_busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = to_flag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt    <= (state == WAIT_OWN && state_nxt == WAIT_OWN) ? to_cnt + 1'b1 : '0;
      timed_out <= to_fire;
      if (to_fire) to_flag_q <= 1'b1;
    end
  end
`else
  assign to_fire      = 1'b0;
  assign timed_out    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Write wins when both request lines are high.
      if (state == IDLE && req) begin
        addr_q  <= sram_addr;
        wdata_q <= sram_wdata;
        we_q    <= sram_wen;
        bank_q  <= select_sram_reg;
      end
      lat_cnt <= (state == RDWAIT) ? lat_cnt + 1'b1 : '0;
      if (to_fire && !we_q)
        rdata_q <= DATA_W'(32'hDEAD_BEEF);
      else if (state == RESP && !we_q && !timed_out)
        rdata_q <= bank_rdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    scan_owns_mem = 1'b0;
    mem0_cen      = 1'b0;
    mem1_cen      = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    sram_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = fft_busy ? WAIT_OWN : ACCESS;
      end
      WAIT_OWN: begin
        if (!fft_busy)    state_nxt = ACCESS;
        else if (to_fire) state_nxt = RESP;
      end
      ACCESS: begin
        scan_owns_mem = 1'b1;
        mem0_cen      = !bank_q;
        mem1_cen      = bank_q;
        mem_we        = we_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        state_nxt     = (we_q || READ_LATENCY == 1) ? RESP : RDWAIT;
      end
      RDWAIT: begin
        scan_owns_mem = 1'b1;
        if (rd_done) state_nxt = RESP;
      end
      RESP: begin
        sram_ready = 1'b1;
        state_nxt  = HOLD;
      end
      HOLD: begin
        if (!req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
